// File: rtl/sa_pe_mac.sv
// sa_pe_mac: output-stationary systolic-array processing element.
// Forwards A east and B south with one register stage. Accumulates a signed or
// unsigned dot product of length cfg_k and posts each finished result into a
// one-entry valid/ready output buffer. The next result starts with no bubble.
// Optional feature macro: PE_SAT_EN. When defined, every accumulate clamps to
// the signed or unsigned AW-bit range. When undefined, sums wrap modulo 2^AW.
module sa_pe_mac #(
  parameter int DW = 8,
  parameter int AW = 24,
  parameter int KW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [KW-1:0] cfg_k,
  input  logic          cfg_signed,
  input  logic          flush,
  input  logic [DW-1:0] a_in,
  input  logic          a_in_vld,
  input  logic [DW-1:0] b_in,
  input  logic          b_in_vld,
  output logic [DW-1:0] a_out,
  output logic          a_out_vld,
  output logic [DW-1:0] b_out,
  output logic          b_out_vld,
  output logic [AW-1:0] c_out,
  output logic          c_out_vld,
  input  logic          c_out_rdy,
  output logic          ovf_err
);

  typedef enum logic {IDLE, ACC} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [KW-1:0]   cnt_q, cnt_d;
  logic [KW-1:0]   k_lat_q, k_lat_d;
  logic            sgn_lat_q, sgn_lat_d;
  logic [DW-1:0]   a_out_q, a_out_d, b_out_q, b_out_d;
  logic            a_out_vld_q, a_out_vld_d, b_out_vld_q, b_out_vld_d;
  logic [AW-1:0]   c_out_q, c_out_d;
  logic            c_out_vld_q, c_out_vld_d;
  logic            ovf_err_q, ovf_err_d;

  logic            fire;
  logic            sgn_eff;
  logic [KW-1:0]   k_cfg;
  logic [KW-1:0]   k_eff;
  logic [KW:0]     cnt_inc;
  logic            complete;
  logic [2*DW-1:0] a_x, b_x, prod;
  logic [AW-1:0]   prod_ext;
  logic [AW-1:0]   sum;

  assign fire    = a_in_vld & b_in_vld & ~flush;
  assign k_cfg   = (cfg_k == '0) ? KW'(1) : cfg_k;
  assign sgn_eff = (state_q == IDLE) ? cfg_signed : sgn_lat_q;
  assign k_eff   = (state_q == IDLE) ? k_cfg : k_lat_q;
  // cnt_q is 0 in IDLE, so one compare covers both the K=1 and the K-th-MAC cases
  assign cnt_inc  = (KW+1)'(cnt_q) + (KW+1)'(1);
  assign complete = fire & (cnt_inc == {1'b0, k_eff});

  // Multiply at 2*DW bits with operands pre-extended by signedness, then extend to AW
  always_comb begin
    a_x  = {{DW{sgn_eff & a_in[DW-1]}}, a_in};
    b_x  = {{DW{sgn_eff & b_in[DW-1]}}, b_in};
    prod = a_x * b_x;
    for (int i = 0; i < AW; i++) begin
      prod_ext[i] = (i < 2*DW) ? prod[i] : (sgn_eff & prod[2*DW-1]);
    end
  end

`ifdef PE_SAT_EN
  logic [AW:0] sum_wide;

  // Add with one guard bit and clamp to the range of the latched signedness
  always_comb begin
    sum_wide = '0;
    sum      = '0;
    if (sgn_eff) begin
      sum_wide = {acc_q[AW-1], acc_q} + {prod_ext[AW-1], prod_ext};
      if (sum_wide[AW] != sum_wide[AW-1]) begin
        sum = sum_wide[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
      end else begin
        sum = sum_wide[AW-1:0];
      end
    end else begin
      sum_wide = {1'b0, acc_q} + {1'b0, prod_ext};
      sum      = sum_wide[AW] ? {AW{1'b1}} : sum_wide[AW-1:0];
    end
  end
`else
  assign sum = acc_q + prod_ext;
`endif

  // Next-state: forwarding, accumulation FSM and result buffer handshake
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    k_lat_d     = k_lat_q;
    sgn_lat_d   = sgn_lat_q;
    c_out_d     = c_out_q;
    c_out_vld_d = c_out_vld_q;
    ovf_err_d   = ovf_err_q;
    a_out_d     = a_in;
    a_out_vld_d = a_in_vld;
    b_out_d     = b_in;
    b_out_vld_d = b_in_vld;

    if (flush) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else if (fire) begin
      if (state_q == IDLE) begin
        k_lat_d   = k_cfg;
        sgn_lat_d = cfg_signed;
      end
      if (complete) begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
      end else begin
        state_d = ACC;
        acc_d   = sum;
        cnt_d   = cnt_inc[KW-1:0];
      end
    end

    if (complete) begin
      if (!c_out_vld_q || c_out_rdy) begin
        c_out_d     = sum;
        c_out_vld_d = 1'b1;
      end else begin
        ovf_err_d = 1'b1;
      end
    end else if (c_out_vld_q && c_out_rdy) begin
      c_out_vld_d = 1'b0;
    end
  end

  // State and output registers, cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      k_lat_q     <= KW'(1);
      sgn_lat_q   <= 1'b0;
      a_out_q     <= '0;
      a_out_vld_q <= 1'b0;
      b_out_q     <= '0;
      b_out_vld_q <= 1'b0;
      c_out_q     <= '0;
      c_out_vld_q <= 1'b0;
      ovf_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      k_lat_q     <= k_lat_d;
      sgn_lat_q   <= sgn_lat_d;
      a_out_q     <= a_out_d;
      a_out_vld_q <= a_out_vld_d;
      b_out_q     <= b_out_d;
      b_out_vld_q <= b_out_vld_d;
      c_out_q     <= c_out_d;
      c_out_vld_q <= c_out_vld_d;
      ovf_err_q   <= ovf_err_d;
    end
  end

  assign a_out     = a_out_q;
  assign a_out_vld = a_out_vld_q;
  assign b_out     = b_out_q;
  assign b_out_vld = b_out_vld_q;
  assign c_out     = c_out_q;
  assign c_out_vld = c_out_vld_q;
  assign ovf_err   = ovf_err_q;

endmodule

// File: tb/tb_sa_pe_mac.sv
// Directed testbench for sa_pe_mac: default-size instance u0 plus a 16-bit
// accumulator instance u1 used for the wrap/saturation case.
module tb_sa_pe_mac;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rst1_n;
  logic [7:0]  cfg_k;
  logic        cfg_signed;
  logic        flush;
  logic [7:0]  a_in, b_in;
  logic        a_in_vld, b_in_vld;
  logic        c_out_rdy;

  logic [7:0]  a_out, b_out;
  logic        a_out_vld, b_out_vld;
  logic [23:0] c_out;
  logic        c_out_vld;
  logic        ovf_err;

  logic [7:0]  a1_out, b1_out;
  logic        a1_out_vld, b1_out_vld;
  logic [15:0] c1_out;
  logic        c1_out_vld;
  logic        ovf1_err;

  int cmp_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  sa_pe_mac #(.DW(8), .AW(24), .KW(8)) u0 (
    .clk(clk), .rst_n(rst_n), .cfg_k(cfg_k), .cfg_signed(cfg_signed), .flush(flush),
    .a_in(a_in), .a_in_vld(a_in_vld), .b_in(b_in), .b_in_vld(b_in_vld),
    .a_out(a_out), .a_out_vld(a_out_vld), .b_out(b_out), .b_out_vld(b_out_vld),
    .c_out(c_out), .c_out_vld(c_out_vld), .c_out_rdy(c_out_rdy), .ovf_err(ovf_err)
  );

  sa_pe_mac #(.DW(8), .AW(16), .KW(8)) u1 (
    .clk(clk), .rst_n(rst1_n), .cfg_k(cfg_k), .cfg_signed(cfg_signed), .flush(flush),
    .a_in(a_in), .a_in_vld(a_in_vld), .b_in(b_in), .b_in_vld(b_in_vld),
    .a_out(a1_out), .a_out_vld(a1_out_vld), .b_out(b1_out), .b_out_vld(b1_out_vld),
    .c_out(c1_out), .c_out_vld(c1_out_vld), .c_out_rdy(c_out_rdy), .ovf_err(ovf1_err)
  );

  // Drive one operand pair for one clock and settle just after the edge
  task automatic applyStimulus(input logic [7:0] a, input logic av,
                               input logic [7:0] b, input logic bv);
    a_in     = a;
    a_in_vld = av;
    b_in     = b;
    b_in_vld = bv;
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Directed sequence of all scenarios
  initial begin
    rst_n = 1'b0; rst1_n = 1'b0;
    cfg_k = 8'd4; cfg_signed = 1'b0; flush = 1'b0; c_out_rdy = 1'b1;
    a_in = '0; b_in = '0; a_in_vld = 1'b0; b_in_vld = 1'b0;

    // reset holds every output at zero even with live inputs
    applyStimulus(8'h55, 1'b1, 8'h66, 1'b1);
    applyStimulus(8'h55, 1'b1, 8'h66, 1'b1);
    checkOutput("rst_a_out", 32'(a_out), 32'h0);
    checkOutput("rst_a_vld", 32'(a_out_vld), 32'h0);
    checkOutput("rst_c_out", 32'(c_out), 32'h0);
    checkOutput("rst_c_vld", 32'(c_out_vld), 32'h0);
    checkOutput("rst_ovf", 32'(ovf_err), 32'h0);
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b0);
    rst_n = 1'b1;

    // unsigned K=4: 1*2+3*4+5*6+7*8 = 100
    applyStimulus(8'd1, 1'b1, 8'd2, 1'b1);
    checkOutput("fwd_a", 32'(a_out), 32'd1);
    checkOutput("fwd_b", 32'(b_out), 32'd2);
    checkOutput("fwd_a_vld", 32'(a_out_vld), 32'd1);
    checkOutput("fwd_b_vld", 32'(b_out_vld), 32'd1);
    applyStimulus(8'd3, 1'b1, 8'd4, 1'b1);
    applyStimulus(8'd5, 1'b1, 8'd6, 1'b1);
    checkOutput("k4_vld_early", 32'(c_out_vld), 32'd0);
    applyStimulus(8'd7, 1'b1, 8'd8, 1'b1);
    checkOutput("k4_c_out", 32'(c_out), 32'd100);
    checkOutput("k4_vld", 32'(c_out_vld), 32'd1);
    applyStimulus(8'd9, 1'b0, 8'd0, 1'b0);
    checkOutput("k4_vld_drop", 32'(c_out_vld), 32'd0);
    checkOutput("k4_c_hold", 32'(c_out), 32'd100);
    checkOutput("fwd_a_novld", 32'(a_out), 32'd9);
    checkOutput("fwd_a_vld_lo", 32'(a_out_vld), 32'd0);

    // signed K=2: (-3*5)+(2*-4) = -23, then back-to-back 1+1 = 2
    cfg_k = 8'd2; cfg_signed = 1'b1;
    applyStimulus(8'hFD, 1'b1, 8'h05, 1'b1);
    applyStimulus(8'h02, 1'b1, 8'hFC, 1'b1);
    checkOutput("sgn_c_out", 32'(c_out), 32'hFFFFE9);
    checkOutput("sgn_vld", 32'(c_out_vld), 32'd1);
    applyStimulus(8'd1, 1'b1, 8'd1, 1'b1);
    checkOutput("b2b_vld_mid", 32'(c_out_vld), 32'd0);
    applyStimulus(8'd1, 1'b1, 8'd1, 1'b1);
    checkOutput("b2b_c_out", 32'(c_out), 32'd2);
    checkOutput("b2b_vld", 32'(c_out_vld), 32'd1);

    // signedness latched at the first MAC: (-2*2)+(-1*1) = -5 despite cfg change
    applyStimulus(8'hFE, 1'b1, 8'h02, 1'b1);
    cfg_signed = 1'b0;
    applyStimulus(8'hFF, 1'b1, 8'h01, 1'b1);
    checkOutput("sgn_latched", 32'(c_out), 32'hFFFFFB);
    applyStimulus(8'd0, 1'b0, 8'd0, 1'b0);

    // gapped valids, K=3, three overlapping (2,2) pairs over seven cycles -> 12
    cfg_k = 8'd3;
    applyStimulus(8'd2, 1'b1, 8'd2, 1'b1);
    applyStimulus(8'd2, 1'b0, 8'd2, 1'b1);
    applyStimulus(8'd2, 1'b1, 8'd2, 1'b1);
    applyStimulus(8'd2, 1'b0, 8'd2, 1'b1);
    applyStimulus(8'd2, 1'b1, 8'd2, 1'b0);
    applyStimulus(8'd2, 1'b0, 8'd2, 1'b1);
    checkOutput("gap_vld_early", 32'(c_out_vld), 32'd0);
    applyStimulus(8'd2, 1'b1, 8'd2, 1'b1);
    checkOutput("gap_c_out", 32'(c_out), 32'd12);
    checkOutput("gap_vld", 32'(c_out_vld), 32'd1);
    applyStimulus(8'd0, 1'b0, 8'd0, 1'b0);

    // backpressure, K=1: second result dropped, overflow flagged
    cfg_k = 8'd1; c_out_rdy = 1'b0;
    applyStimulus(8'd3, 1'b1, 8'd3, 1'b1);
    checkOutput("bp_c_out", 32'(c_out), 32'd9);
    checkOutput("bp_ovf_lo", 32'(ovf_err), 32'd0);
    applyStimulus(8'd4, 1'b1, 8'd4, 1'b1);
    checkOutput("bp_c_keep", 32'(c_out), 32'd9);
    checkOutput("bp_ovf", 32'(ovf_err), 32'd1);
    checkOutput("bp_vld", 32'(c_out_vld), 32'd1);
    applyStimulus(8'd0, 1'b0, 8'd0, 1'b0);
    checkOutput("bp_vld_hold", 32'(c_out_vld), 32'd1);
    c_out_rdy = 1'b1;
    applyStimulus(8'd0, 1'b0, 8'd0, 1'b0);
    checkOutput("bp_vld_drop", 32'(c_out_vld), 32'd0);
    checkOutput("bp_c_after", 32'(c_out), 32'd9);

    // K=1 streaming keeps c_out_vld high; cfg_k=0 behaves as 1
    applyStimulus(8'd2, 1'b1, 8'd3, 1'b1);
    checkOutput("k1_c0", 32'(c_out), 32'd6);
    applyStimulus(8'd4, 1'b1, 8'd5, 1'b1);
    checkOutput("k1_c1", 32'(c_out), 32'd20);
    checkOutput("k1_vld", 32'(c_out_vld), 32'd1);
    cfg_k = 8'd0;
    applyStimulus(8'd7, 1'b1, 8'd7, 1'b1);
    checkOutput("k0_c_out", 32'(c_out), 32'd49);
    checkOutput("k0_vld", 32'(c_out_vld), 32'd1);
    applyStimulus(8'd0, 1'b0, 8'd0, 1'b0);

    // flush after two MACs; operands in the flush cycle are ignored
    cfg_k = 8'd4;
    applyStimulus(8'd10, 1'b1, 8'd10, 1'b1);
    applyStimulus(8'd10, 1'b1, 8'd10, 1'b1);
    flush = 1'b1;
    applyStimulus(8'd10, 1'b1, 8'd10, 1'b1);
    flush = 1'b0;
    checkOutput("fl_ovf_kept", 32'(ovf_err), 32'd1);
    checkOutput("fl_fwd", 32'(a_out), 32'd10);
    applyStimulus(8'd1, 1'b1, 8'd1, 1'b1);
    applyStimulus(8'd1, 1'b1, 8'd1, 1'b1);
    applyStimulus(8'd1, 1'b1, 8'd1, 1'b1);
    checkOutput("fl_vld_early", 32'(c_out_vld), 32'd0);
    applyStimulus(8'd1, 1'b1, 8'd1, 1'b1);
    checkOutput("fl_c_out", 32'(c_out), 32'd4);
    checkOutput("fl_vld", 32'(c_out_vld), 32'd1);
    applyStimulus(8'd0, 1'b0, 8'd0, 1'b0);

    // asynchronous reset mid-accumulation
    applyStimulus(8'd5, 1'b1, 8'd5, 1'b1);
    applyStimulus(8'd5, 1'b1, 8'd5, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_a_out", 32'(a_out), 32'h0);
    checkOutput("arst_a_vld", 32'(a_out_vld), 32'h0);
    checkOutput("arst_c_out", 32'(c_out), 32'h0);
    checkOutput("arst_ovf", 32'(ovf_err), 32'h0);
    applyStimulus(8'd0, 1'b0, 8'd0, 1'b0);
    rst_n = 1'b1;
    cfg_k = 8'd2;
    applyStimulus(8'd3, 1'b1, 8'd3, 1'b1);
    applyStimulus(8'd3, 1'b1, 8'd3, 1'b1);
    checkOutput("arst_fresh_c", 32'(c_out), 32'd18);
    checkOutput("arst_fresh_vld", 32'(c_out_vld), 32'd1);
    applyStimulus(8'd0, 1'b0, 8'd0, 1'b0);

    // 255*255 twice: wraps at AW=16 (or clamps with PE_SAT_EN), fits at AW=24
    rst1_n = 1'b1;
    applyStimulus(8'd0, 1'b0, 8'd0, 1'b0);
    applyStimulus(8'hFF, 1'b1, 8'hFF, 1'b1);
    applyStimulus(8'hFF, 1'b1, 8'hFF, 1'b1);
`ifdef PE_SAT_EN
    checkOutput("aw16_c_out", 32'(c1_out), 32'hFFFF);
`else
    checkOutput("aw16_c_out", 32'(c1_out), 32'hFC02);
`endif
    checkOutput("aw16_vld", 32'(c1_out_vld), 32'd1);
    checkOutput("aw24_c_out", 32'(c_out), 32'h1FC02);
    applyStimulus(8'd0, 1'b0, 8'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
